dr_load_sequencer: RTL and testbench

DR_LOAD_SEQUENCER -- requirements
Module: dr_load_sequencer

---
 rtl/dr_load_sequencer.sv | 141 ++++++++++++++
 tb/tb_dr_load_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_load_sequencer.sv
// Sequences single-byte or four-byte memory reads into a shifting data register,
// one byte per request/write pair, with a per-byte ack timeout.
module dr_load_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              dr_e,
  output logic [1:0]        dr_funsel,
  output logic [7:0]        dr_i,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        wait_q, wait_d;
  logic [7:0]        data_q, data_d;

  logic [2:0] idx_inc;
  logic [7:0] wait_inc;

  assign idx_inc  = idx_q + 3'd1;
  assign wait_inc = wait_q + 8'd1;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    data_d  = data_q;
    mem_req = 1'b0;
    dr_e    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          base_d  = base_addr;
          addr_d  = base_addr;
          cnt_d   = mode[1] ? 3'd4 : 3'd1;
          idx_d   = 3'd0;
          wait_d  = 8'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        // An ack arriving on the final wait cycle still completes the byte.
        if (mem_ack) begin
          data_d  = mem_data;
          wait_d  = 8'd0;
          state_d = S_WRITE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_C) begin
            state_d = S_ERR;
          end
        end
      end
      S_WRITE: begin
        dr_e  = 1'b1;
        idx_d = idx_inc;
        if (idx_inc == cnt_q) begin
          state_d = S_DONE;
        end else begin
          // Address register only moves when another byte follows, so it holds when idle.
          addr_d  = base_q + ADDR_W'(idx_inc);
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      base_q  <= '0;
      addr_q  <= '0;
      idx_q   <= 3'd0;
      cnt_q   <= 3'd0;
      wait_q  <= 8'd0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = addr_q;
  assign dr_funsel = mode_q;
  assign dr_i      = data_q;

endmodule

// File: tb/tb_dr_load_sequencer.sv
// Directed bench for dr_load_sequencer: a scripted memory responder and a
// model of the external shifting data register check each scenario.
module tb_dr_load_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] base_addr = 16'h0000;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        dr_e;
  logic [1:0]  dr_funsel;
  logic [7:0]  dr_i;
  logic        busy;
  logic        done;
  logic        err;

  dr_load_sequencer #(.ADDR_W(16), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .dr_e      (dr_e),
    .dr_funsel (dr_funsel),
    .dr_i      (dr_i),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc, done_cyc, err_cyc;
  int dr_e_cnt, done_cnt, err_cnt, req_cnt, funsel_bad;
  int ack_wait = 0;
  int wait_cnt, byte_ptr;
  bit noise = 1'b0;
  bit saw_end;
  logic [1:0]  exp_funsel = 2'b00;
  logic [31:0] dr_model = 32'h0;
  logic [7:0]  mem_bytes[$];
  logic [15:0] addr_log[$];

  // One clock cycle: observe outputs at the falling edge, then drive the next inputs.
  task automatic tick(input logic s, input logic [1:0] m, input logic [15:0] b);
    @(negedge clk);
    cyc++;
    saw_end = 1'b0;
    if (dr_e === 1'b1) begin
      dr_e_cnt++;
      if (dr_funsel !== exp_funsel) funsel_bad++;
      case (dr_funsel)
        2'b00:   dr_model = {{24{dr_i[7]}}, dr_i};
        2'b01:   dr_model = {24'h0, dr_i};
        2'b10:   dr_model = {dr_model[23:0], dr_i};
        default: dr_model = {dr_i, dr_model[31:8]};
      endcase
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; saw_end = 1'b1; end
    if (err === 1'b1)  begin err_cnt++;  err_cyc = cyc;  saw_end = 1'b1; end
    if (mem_req === 1'b1) req_cnt++;
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    if (mem_req === 1'b1) begin
      if (byte_ptr < mem_bytes.size() && wait_cnt == ack_wait) begin
        mem_ack  = 1'b1;
        mem_data = mem_bytes[byte_ptr];
        addr_log.push_back(mem_addr);
        byte_ptr++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else if (noise) begin
      mem_ack  = 1'b1;
      mem_data = 8'hEE;
    end
    start     = s;
    mode      = m;
    base_addr = b;
  endtask

  task automatic clear_stats();
    dr_e_cnt = 0; done_cnt = 0; err_cnt = 0; req_cnt = 0; funsel_bad = 0;
    done_cyc = -1; err_cyc = -1; byte_ptr = 0; wait_cnt = 0;
    addr_log.delete();
  endtask

  task automatic start_op(input logic [1:0] m, input logic [15:0] b);
    exp_funsel = m;
    tick(1'b1, m, b);
    start_cyc = cyc;
  endtask

  task automatic run_to_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1'b0, 2'b00, 16'h0000);
      if (saw_end) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_stats();
    rst = 1'b1;
    repeat (3) tick(1'b0, 2'b00, 16'h0000);
    n_checks++;
    if ({busy, mem_req, dr_e, done, err, mem_addr, dr_funsel, dr_i} !== 31'h0)
      $display("FAIL reset_outputs: got busy=%b req=%b dr_e=%b done=%b err=%b addr=%h fs=%b dr_i=%h expected all zero",
               busy, mem_req, dr_e, done, err, mem_addr, dr_funsel, dr_i);
    else n_pass++;
    tick(1'b1, 2'b10, 16'h1234);
    tick(1'b0, 2'b00, 16'h0000);
    n_checks++;
    if ({busy, mem_req, mem_addr} !== 18'h0)
      $display("FAIL reset_over_start: got busy=%b req=%b addr=%h expected 0 0 0000", busy, mem_req, mem_addr);
    else n_pass++;
    rst = 1'b0;
    tick(1'b0, 2'b00, 16'h0000);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: got busy=%b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_byte_load();
    bit ok;
    clear_stats();
    mem_bytes = '{8'h85};
    start_op(2'b01, 16'h0010);
    run_to_end(ok);
    n_checks++;
    if (!ok || done_cnt != 1 || err_cnt != 0 || dr_e_cnt != 1 || funsel_bad != 0)
      $display("FAIL zext_flow: got ok=%0d done=%0d err=%0d dr_e=%0d fsbad=%0d expected 1 1 0 1 0",
               ok, done_cnt, err_cnt, dr_e_cnt, funsel_bad);
    else n_pass++;
    n_checks++;
    if (addr_log.size() != 1 || addr_log[0] !== 16'h0010)
      $display("FAIL zext_addr: got %h (n=%0d) expected 0010", addr_log[0], addr_log.size());
    else n_pass++;
    n_checks++;
    if (done_cyc - start_cyc != 3) $display("FAIL zext_latency: got %0d expected 3", done_cyc - start_cyc);
    else n_pass++;
    n_checks++;
    if (dr_model !== 32'h0000_0085) $display("FAIL zext_dr: got %h expected 00000085", dr_model);
    else n_pass++;
    tick(1'b0, 2'b00, 16'h0000);
    n_checks++;
    if ({busy, mem_addr, dr_funsel, dr_i} !== {1'b0, 16'h0010, 2'b01, 8'h85})
      $display("FAIL idle_hold: got busy=%b addr=%h fs=%b dr_i=%h expected 0 0010 01 85", busy, mem_addr, dr_funsel, dr_i);
    else n_pass++;
    clear_stats();
    mem_bytes = '{8'h85};
    start_op(2'b00, 16'h0011);
    run_to_end(ok);
    n_checks++;
    if (!ok || dr_model !== 32'hFFFF_FF85 || funsel_bad != 0)
      $display("FAIL sext_dr: got ok=%0d dr=%h fsbad=%0d expected 1 ffffff85 0", ok, dr_model, funsel_bad);
    else n_pass++;
  endtask

  task automatic test_word(input logic [1:0] m, input logic [15:0] b, input logic [63:0] exp_addrs,
                           input logic [31:0] exp_dr, input string name);
    bit ok;
    clear_stats();
    mem_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    start_op(m, b);
    run_to_end(ok);
    n_checks++;
    if (!ok || done_cnt != 1 || err_cnt != 0 || dr_e_cnt != 4 || funsel_bad != 0)
      $display("FAIL %s_flow: got ok=%0d done=%0d err=%0d dr_e=%0d fsbad=%0d expected 1 1 0 4 0",
               name, ok, done_cnt, err_cnt, dr_e_cnt, funsel_bad);
    else n_pass++;
    n_checks++;
    if (addr_log.size() != 4 || {addr_log[0], addr_log[1], addr_log[2], addr_log[3]} !== exp_addrs)
      $display("FAIL %s_addrs: got %h %h %h %h expected %h", name,
               addr_log[0], addr_log[1], addr_log[2], addr_log[3], exp_addrs);
    else n_pass++;
    n_checks++;
    if (done_cyc - start_cyc != 9) $display("FAIL %s_latency: got %0d expected 9", name, done_cyc - start_cyc);
    else n_pass++;
    n_checks++;
    if (dr_model !== exp_dr) $display("FAIL %s_dr: got %h expected %h", name, dr_model, exp_dr);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    logic [31:0] exp_dr;
    clear_stats();
    mem_bytes.delete();
    start_op(2'b00, 16'h0040);
    run_to_end(ok);
    n_checks++;
    if (!ok || err_cnt != 1 || done_cnt != 0 || dr_e_cnt != 0 || req_cnt != 15)
      $display("FAIL timeout_flow: got ok=%0d err=%0d done=%0d dr_e=%0d req=%0d expected 1 1 0 0 15",
               ok, err_cnt, done_cnt, dr_e_cnt, req_cnt);
    else n_pass++;
    n_checks++;
    if (err_cyc - start_cyc != 16) $display("FAIL timeout_latency: got %0d expected 16", err_cyc - start_cyc);
    else n_pass++;
    tick(1'b0, 2'b00, 16'h0000);
    n_checks++;
    if ({busy, mem_req, err} !== 3'b000) $display("FAIL timeout_idle: got busy=%b req=%b err=%b expected 000", busy, mem_req, err);
    else n_pass++;

    clear_stats();
    exp_dr = {dr_model[15:0], 8'hAA, 8'hBB};
    mem_bytes = '{8'hAA, 8'hBB};
    start_op(2'b10, 16'h0060);
    run_to_end(ok);
    tick(1'b0, 2'b00, 16'h0000);
    n_checks++;
    if (!ok || err_cnt != 1 || dr_e_cnt != 2 || req_cnt != 17 || dr_model !== exp_dr || dr_i !== 8'hBB)
      $display("FAIL partial_err: got ok=%0d err=%0d dr_e=%0d req=%0d dr=%h dr_i=%h expected 1 1 2 17 %h bb",
               ok, err_cnt, dr_e_cnt, req_cnt, dr_model, dr_i, exp_dr);
    else n_pass++;

    clear_stats();
    mem_bytes = '{8'h7F};
    ack_wait = 14;
    start_op(2'b00, 16'h0050);
    run_to_end(ok);
    ack_wait = 0;
    n_checks++;
    if (!ok || done_cnt != 1 || err_cnt != 0 || done_cyc - start_cyc != 17 || dr_model !== 32'h0000_007F)
      $display("FAIL late_ack: got ok=%0d done=%0d err=%0d lat=%0d dr=%h expected 1 1 0 17 0000007f",
               ok, done_cnt, err_cnt, done_cyc - start_cyc, dr_model);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int req_before;
    clear_stats();
    mem_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_op(2'b10, 16'h0080);
    for (int i = 0; i < 50 && dr_e_cnt < 2; i++) tick(1'b0, 2'b00, 16'h0000);
    rst = 1'b1;
    tick(1'b0, 2'b00, 16'h0000);
    n_checks++;
    if ({busy, mem_req, dr_e, done, err, mem_addr, dr_funsel, dr_i} !== 31'h0)
      $display("FAIL midreset_outputs: got busy=%b req=%b dr_e=%b done=%b err=%b addr=%h fs=%b dr_i=%h expected all zero",
               busy, mem_req, dr_e, done, err, mem_addr, dr_funsel, dr_i);
    else n_pass++;
    rst = 1'b0;
    req_before = req_cnt;
    repeat (5) tick(1'b0, 2'b00, 16'h0000);
    n_checks++;
    if (req_cnt != req_before || dr_e_cnt != 2 || done_cnt != 0 || err_cnt != 0)
      $display("FAIL midreset_quiet: got req=%0d dr_e=%0d done=%0d err=%0d expected %0d 2 0 0",
               req_cnt, dr_e_cnt, done_cnt, err_cnt, req_before);
    else n_pass++;
    clear_stats();
    mem_bytes = '{8'h3C};
    start_op(2'b01, 16'h0020);
    run_to_end(ok);
    n_checks++;
    if (!ok || done_cnt != 1 || done_cyc - start_cyc != 3 || dr_model !== 32'h0000_003C)
      $display("FAIL midreset_restart: got ok=%0d done=%0d lat=%0d dr=%h expected 1 1 3 0000003c",
               ok, done_cnt, done_cyc - start_cyc, dr_model);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_stats();
    noise = 1'b1;
    mem_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    start_op(2'b10, 16'h0200);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick((i % 3) == 0, 2'b00, 16'h7777);
      if (saw_end) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || done_cnt != 1 || dr_e_cnt != 4 || funsel_bad != 0 || dr_model !== 32'hA1B2_C3D4)
      $display("FAIL busy_start_ignored: got ok=%0d done=%0d dr_e=%0d fsbad=%0d dr=%h expected 1 1 4 0 a1b2c3d4",
               ok, done_cnt, dr_e_cnt, funsel_bad, dr_model);
    else n_pass++;
    clear_stats();
    mem_bytes = '{8'h5A};
    start_op(2'b01, 16'h0300);
    run_to_end(ok);
    tick(1'b0, 2'b00, 16'h0000);
    noise = 1'b0;
    n_checks++;
    if (!ok || done_cnt != 1 || done_cyc - start_cyc != 3 || dr_model !== 32'h0000_005A ||
        addr_log.size() != 1 || addr_log[0] !== 16'h0300 || dr_i !== 8'h5A)
      $display("FAIL start_after_done: got ok=%0d done=%0d lat=%0d dr=%h addr=%h dr_i=%h expected 1 1 3 0000005a 0300 5a",
               ok, done_cnt, done_cyc - start_cyc, dr_model, addr_log[0], dr_i);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_byte_load();
    test_word(2'b10, 16'h0100, {16'h0100, 16'h0101, 16'h0102, 16'h0103}, 32'h1234_5678, "word_be");
    test_word(2'b11, 16'h0100, {16'h0100, 16'h0101, 16'h0102, 16'h0103}, 32'h7856_3412, "word_le");
    test_word(2'b10, 16'hFFFE, {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001}, 32'h1234_5678, "wrap");
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
